alu_operand_loader: RTL and testbench

- Front-end stage feeding the ALU on the board.
- Debounces the three load buttons (A, B, opcode) and detects press edges.
- On each press, captures the switch bank into the matching operand or opcode register.
- Signals the downstream ALU when a complete operand set (A, B, valid opcode) is present; rejects unsupported opcodes.

---
 rtl/alu_operand_loader_if.sv | 34 +++
 rtl/alu_operand_loader.sv | 135 +++++++++++++
 tb/tb_alu_operand_loader.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/alu_operand_loader_if.sv
// Board-side bundle for the ALU operand loader: the switch bank, the three
// raw load buttons and the latched operand/opcode outputs.
//   i_sw      switch bank (quasi-static)
//   i_btn_*   raw load buttons for A, B and opcode (active high, async)
//   o_data_*  latched operands, o_op latched opcode
//   o_ready   level: full operand set loaded since reset
//   o_valid   one-cycle pulse: operand set complete or updated
//   o_op_err  one-cycle pulse: unsupported opcode rejected
// master = board/stimulus side, slave = loader side.
interface alu_operand_loader_if #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
);
  logic [NB_DATA-1:0] i_sw;
  logic               i_btn_a;
  logic               i_btn_b;
  logic               i_btn_op;
  logic [NB_DATA-1:0] o_data_a;
  logic [NB_DATA-1:0] o_data_b;
  logic [NB_OP-1:0]   o_op;
  logic               o_ready;
  logic               o_valid;
  logic               o_op_err;

  modport master (
    output i_sw, i_btn_a, i_btn_b, i_btn_op,
    input  o_data_a, o_data_b, o_op, o_ready, o_valid, o_op_err
  );

  modport slave (
    input  i_sw, i_btn_a, i_btn_b, i_btn_op,
    output o_data_a, o_data_b, o_op, o_ready, o_valid, o_op_err
  );
endinterface

// File: rtl/alu_operand_loader.sv
// ALU operand loader: synchronizes and debounces the A/B/opcode load
// buttons, captures the switch bank into the matching register on each
// press, and flags complete operand sets and rejected opcodes.
// Ports:
//   i_clock  system clock, rising edge
//   i_reset  asynchronous active-low reset
//   bus      alu_operand_loader_if.slave (switches, buttons, results)
module alu_operand_loader #(
  parameter int NB_DATA         = 8,
  parameter int NB_OP           = 6,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int NB_CNT          = $clog2(DEBOUNCE_CYCLES)
) (
  input logic                 i_clock,
  input logic                 i_reset,
  alu_operand_loader_if.slave bus
);

  localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(DEBOUNCE_CYCLES - 1);

  // Channel index: 0 = A, 1 = B, 2 = opcode
  logic [2:0]             raw;
  logic [2:0]             sync1;
  logic [2:0]             sync2;
  logic [2:0]             stable;
  logic [2:0][NB_CNT-1:0] cnt;
  logic [2:0]             press;

  logic [NB_DATA-1:0] data_a;
  logic [NB_DATA-1:0] data_b;
  logic [NB_OP-1:0]   op;
  logic               loaded_a;
  logic               loaded_b;
  logic               loaded_op;
  logic               ready;
  logic               valid;
  logic               op_err;

  logic [NB_OP-1:0] op_code;
  logic             op_ok;
  logic             load_a;
  logic             load_b;
  logic             load_op;
  logic             bad_op;
  logic             all_next;

  assign raw = {bus.i_btn_op, bus.i_btn_b, bus.i_btn_a};

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      sync1  <= '0;
      sync2  <= '0;
      stable <= '0;
      cnt    <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int unsigned i = 0; i < 3; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + NB_CNT'(1);
        end
      end
    end
  end

  // A press is the edge on which stable is about to go 0->1, so the load
  // lands on the same edge as the stable-level flip.
  always_comb begin
    press = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      press[i] = ~stable[i] & sync2[i] & (cnt[i] == CNT_LAST);
    end
  end

  assign op_code = bus.i_sw[NB_OP-1:0];

  always_comb begin
    op_ok = 1'b0;
    case (op_code)
      NB_OP'(6'b100000), NB_OP'(6'b100010), NB_OP'(6'b100100),
      NB_OP'(6'b100101), NB_OP'(6'b100110), NB_OP'(6'b000011),
      NB_OP'(6'b000010), NB_OP'(6'b100111): op_ok = 1'b1;
      default:                              op_ok = 1'b0;
    endcase
  end

  assign load_a   = press[0];
  assign load_b   = press[1];
  assign load_op  = press[2] & op_ok;
  assign bad_op   = press[2] & ~op_ok;
  assign all_next = (loaded_a | load_a) & (loaded_b | load_b) & (loaded_op | load_op);

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      data_a    <= '0;
      data_b    <= '0;
      op        <= '0;
      loaded_a  <= 1'b0;
      loaded_b  <= 1'b0;
      loaded_op <= 1'b0;
      ready     <= 1'b0;
      valid     <= 1'b0;
      op_err    <= 1'b0;
    end else begin
      if (load_a) begin
        data_a   <= bus.i_sw;
        loaded_a <= 1'b1;
      end
      if (load_b) begin
        data_b   <= bus.i_sw;
        loaded_b <= 1'b1;
      end
      if (load_op) begin
        op        <= op_code;
        loaded_op <= 1'b1;
      end
      ready  <= all_next;
      valid  <= (load_a | load_b | load_op) & all_next;
      op_err <= bad_op;
    end
  end

  assign bus.o_data_a = data_a;
  assign bus.o_data_b = data_b;
  assign bus.o_op     = op;
  assign bus.o_ready  = ready;
  assign bus.o_valid  = valid;
  assign bus.o_op_err = op_err;

endmodule

// File: tb/tb_alu_operand_loader.sv
module tb_alu_operand_loader;
  localparam int NB_DATA = 8;
  localparam int NB_OP   = 6;
  localparam int DC      = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_operand_loader_if #(.NB_DATA(NB_DATA), .NB_OP(NB_OP)) bus ();

  alu_operand_loader #(
    .NB_DATA(NB_DATA),
    .NB_OP(NB_OP),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .i_clock(clk),
    .i_reset(rst_n),
    .bus(bus)
  );

  int vecs      = 0;
  int errs      = 0;
  int valid_cnt = 0;
  int err_cnt   = 0;
  int chg_a     = 0;
  logic [NB_DATA-1:0] prev_a = '0;

  // Pulse/change monitors sampled on the falling edge
  always @(negedge clk) begin
    if (bus.o_valid === 1'b1) valid_cnt++;
    if (bus.o_op_err === 1'b1) err_cnt++;
    if (bus.o_data_a !== prev_a) chg_a++;
    prev_a = bus.o_data_a;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int vb, eb, cb;

  initial begin
    bus.i_sw     = '0;
    bus.i_btn_a  = 1'b0;
    bus.i_btn_b  = 1'b0;
    bus.i_btn_op = 1'b0;
    tick(3);
    check("rst_data_a", 32'(bus.o_data_a), 32'h0);
    check("rst_data_b", 32'(bus.o_data_b), 32'h0);
    check("rst_op",     32'(bus.o_op),     32'h0);
    check("rst_flags",  32'({bus.o_ready, bus.o_valid, bus.o_op_err}), 32'h0);
    rst_n = 1'b1;
    tick(2);

    // Clean A press, load 5 edges after first sample
    cb = chg_a; vb = valid_cnt;
    bus.i_sw = 8'h80; bus.i_btn_a = 1'b1;
    tick(5);
    check("a_early", 32'(bus.o_data_a), 32'h0);
    tick(1);
    check("a_load",  32'(bus.o_data_a), 32'h80);
    check("a_ready", 32'(bus.o_ready),  32'h0);
    tick(4);
    bus.i_btn_a = 1'b0;
    tick(10);
    check("a_single", 32'(chg_a - cb), 32'd1);
    check("a_novalid", 32'(valid_cnt - vb), 32'd0);

    // B press
    bus.i_sw = 8'h03; bus.i_btn_b = 1'b1;
    tick(8);
    bus.i_btn_b = 1'b0;
    tick(10);
    check("b_load",  32'(bus.o_data_b), 32'h03);
    check("b_ready", 32'(bus.o_ready),  32'h0);

    // OP press NOR completes the set
    vb = valid_cnt; eb = err_cnt;
    bus.i_sw = 8'h27; bus.i_btn_op = 1'b1;
    tick(5);
    check("op_early_ready", 32'(bus.o_ready), 32'h0);
    tick(1);
    check("op_load",   32'(bus.o_op),    32'h27);
    check("op_ready",  32'(bus.o_ready), 32'h1);
    check("op_valid",  32'(bus.o_valid), 32'h1);
    tick(1);
    check("op_valid_end", 32'(bus.o_valid), 32'h0);
    tick(6);
    bus.i_btn_op = 1'b0;
    tick(10);
    check("op_valid_cnt", 32'(valid_cnt - vb), 32'd1);
    check("op_no_err",    32'(err_cnt - eb),   32'd0);

    // Bouncy A press: 1,1,0 then steady 1
    cb = chg_a; vb = valid_cnt;
    bus.i_sw = 8'h55;
    bus.i_btn_a = 1'b1; tick(2);
    bus.i_btn_a = 1'b0; tick(1);
    bus.i_btn_a = 1'b1; tick(5);
    check("bnc_early", 32'(bus.o_data_a), 32'h80);
    tick(1);
    check("bnc_load",  32'(bus.o_data_a), 32'h55);
    tick(6);
    bus.i_btn_a = 1'b0;
    tick(10);
    check("bnc_single", 32'(chg_a - cb),     32'd1);
    check("bnc_valid",  32'(valid_cnt - vb), 32'd1);

    // Unsupported opcode
    vb = valid_cnt; eb = err_cnt;
    bus.i_sw = 8'h3F; bus.i_btn_op = 1'b1;
    tick(6);
    check("bad_err",  32'(bus.o_op_err), 32'h1);
    check("bad_keep", 32'(bus.o_op),     32'h27);
    tick(1);
    check("bad_err_end", 32'(bus.o_op_err), 32'h0);
    tick(4);
    bus.i_btn_op = 1'b0;
    tick(10);
    check("bad_err_cnt",  32'(err_cnt - eb),   32'd1);
    check("bad_no_valid", 32'(valid_cnt - vb), 32'd0);
    check("bad_ready",    32'(bus.o_ready),    32'h1);

    // Simultaneous A and B
    vb = valid_cnt;
    bus.i_sw = 8'hF0; bus.i_btn_a = 1'b1; bus.i_btn_b = 1'b1;
    tick(5);
    check("ab_early", 32'(bus.o_data_a), 32'h55);
    tick(1);
    check("ab_a",     32'(bus.o_data_a), 32'hF0);
    check("ab_b",     32'(bus.o_data_b), 32'hF0);
    check("ab_valid", 32'(bus.o_valid),  32'h1);
    tick(4);
    bus.i_btn_a = 1'b0; bus.i_btn_b = 1'b0;
    tick(10);
    check("ab_valid_cnt", 32'(valid_cnt - vb), 32'd1);

    // Reset during pending OP debounce (cnt=2 after 4 edges)
    bus.i_sw = 8'h20; bus.i_btn_op = 1'b1;
    tick(4);
    rst_n = 1'b0;
    #1;
    check("mid_rst_a",     32'(bus.o_data_a), 32'h0);
    check("mid_rst_b",     32'(bus.o_data_b), 32'h0);
    check("mid_rst_op",    32'(bus.o_op),     32'h0);
    check("mid_rst_ready", 32'(bus.o_ready),  32'h0);
    tick(2);
    rst_n = 1'b1;
    vb = valid_cnt;
    tick(5);
    check("post_rst_early", 32'(bus.o_op), 32'h0);
    tick(1);
    check("post_rst_load",  32'(bus.o_op),    32'h20);
    check("post_rst_ready", 32'(bus.o_ready), 32'h0);
    bus.i_btn_op = 1'b0;
    tick(10);
    check("post_rst_novalid", 32'(valid_cnt - vb), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
